// File: rtl/mc_datapath_bus.sv
// Multicycle datapath with a registered memory data register and a valid/ready bus master.
// Handles store lane steering, load extension, and misalignment/timeout error reporting.
module mc_datapath_bus #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          NREGS     = 32,
  parameter int          TIMEOUT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enBranch,
  input  logic        pcUpdate,
  input  logic        irWrite,
  input  logic        regWrite,
  input  logic        addrSrc,
  input  logic [1:0]  regSrc,
  input  logic [2:0]  immedSrc,
  input  logic [1:0]  aluSrcA,
  input  logic [1:0]  aluSrcB,
  input  logic [3:0]  aluOp,
  input  logic        memReq,
  input  logic        memWr,
  output logic        memDone,
  output logic        memErr,
  output logic [31:0] inst_out,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic        bus_we,
  output logic        bus_valid,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  // Bus handshake: a beat completes on the rising edge where bus_valid && bus_ready;
  // bus_addr/be/we/wdata are held constant for as long as bus_valid is high.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FIN = 2'd2} bus_state_t;
  bus_state_t state, state_nxt;

  logic [31:0] pc, inst, old_pc, mdr, cnt;
  logic [31:0] regs [32];
  logic [31:0] rs1_data, rs2_data, imm, alu_a, alu_b, alu_result, ea, wd, ext;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;
  logic [1:0]  req_size, size_q, off_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        take_branch, misaligned, err_q, start, expire;

  function automatic logic reg_ok(input logic [4:0] idx);
    return (idx != 5'd0) && ((NREGS == 32) || !idx[4]);
  endfunction

  assign rs1_data = reg_ok(inst[19:15]) ? regs[inst[19:15]] : 32'd0;
  assign rs2_data = reg_ok(inst[24:20]) ? regs[inst[24:20]] : 32'd0;

  always_ff @(posedge clk) begin
    if (regWrite && reg_ok(inst[11:7])) regs[inst[11:7]] <= wd;
  end

  always_comb begin
    case (immedSrc)
      3'd1:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      3'd2:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'd3:    imm = {inst[31:12], 12'd0};
      3'd4:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = {{20{inst[31]}}, inst[31:20]};
    endcase
    case (aluSrcA)
      2'd0:    alu_a = rs1_data;
      2'd1:    alu_a = pc;
      2'd2:    alu_a = old_pc;
      default: alu_a = 32'd0;
    endcase
    case (aluSrcB)
      2'd0:    alu_b = rs2_data;
      2'd1:    alu_b = imm;
      2'd2:    alu_b = 32'd4;
      default: alu_b = 32'd0;
    endcase
  end

  always_comb begin
    case (aluOp)
      4'b1000: alu_result = alu_a - alu_b;
      4'b0001: alu_result = alu_a << alu_b[4:0];
      4'b0010: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0011: alu_result = {31'd0, alu_a < alu_b};
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b0101: alu_result = alu_a >> alu_b[4:0];
      4'b1101: alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
      4'b0110: alu_result = alu_a | alu_b;
      4'b0111: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_b;
      default: alu_result = alu_a + alu_b;
    endcase
  end

  always_comb begin
    case (inst[14:12])
      3'b000:  take_branch = (rs1_data == rs2_data);
      3'b001:  take_branch = (rs1_data != rs2_data);
      3'b100:  take_branch = ($signed(rs1_data) < $signed(rs2_data));
      3'b101:  take_branch = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  take_branch = (rs1_data < rs2_data);
      3'b111:  take_branch = (rs1_data >= rs2_data);
      default: take_branch = 1'b0;
    endcase
  end

  // Load extension uses the offset/size latched when the access started.
  always_comb begin
    case (off_q)
      2'd1:    byte_sel = mdr[15:8];
      2'd2:    byte_sel = mdr[23:16];
      2'd3:    byte_sel = mdr[31:24];
      default: byte_sel = mdr[7:0];
    endcase
    half_sel = off_q[1] ? mdr[31:16] : mdr[15:0];
    case (size_q)
      2'd0:    ext = inst[14] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'd1:    ext = inst[14] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ext = mdr;
    endcase
    case (regSrc)
      2'd0:    wd = pc;
      2'd2:    wd = ext;
      default: wd = alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_VEC;
      inst   <= 32'd0;
      old_pc <= 32'd0;
    end else begin
      if (pcUpdate || (enBranch && take_branch)) pc <= alu_result;
      if (irWrite) begin
        inst   <= mdr;
        old_pc <= pc;
      end
    end
  end

  // Fetches (addrSrc=0) are always word sized; data accesses take size from funct3.
  assign ea       = addrSrc ? alu_result : pc;
  assign req_size = addrSrc ? inst[13:12] : 2'd2;
  assign misaligned = (req_size == 2'd3) || ((req_size == 2'd1) && ea[0]) ||
                      ((req_size == 2'd2) && (ea[1:0] != 2'd0));

  always_comb begin
    case (req_size)
      2'd0: begin
        lane_be    = 4'b0001 << ea[1:0];
        lane_wdata = {4{rs2_data[7:0]}};
      end
      2'd1: begin
        lane_be    = 4'b0011 << ea[1:0];
        lane_wdata = {2{rs2_data[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = rs2_data;
      end
    endcase
  end

  assign start  = (state == IDLE) && memReq;
  assign expire = (state == REQ) && !bus_ready && (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (memReq) state_nxt = misaligned ? FIN : REQ;
      REQ:     if (bus_ready || expire) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      bus_we    <= 1'b0;
      off_q     <= 2'd0;
      size_q    <= 2'd0;
      err_q     <= 1'b0;
      cnt       <= 32'd0;
      mdr       <= 32'd0;
    end else begin
      if (start) begin
        bus_addr  <= {ea[31:2], 2'b00};
        bus_be    <= lane_be;
        bus_wdata <= lane_wdata;
        bus_we    <= memWr;
        off_q     <= ea[1:0];
        size_q    <= req_size;
        err_q     <= misaligned;
        cnt       <= 32'd0;
      end
      if (state == REQ) begin
        if (bus_ready) begin
          if (!bus_we) mdr <= bus_rdata;
          cnt <= 32'd0;
        end else if (expire) begin
          err_q <= 1'b1;
          cnt   <= 32'd0;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end
    end
  end

  assign bus_valid = (state == REQ);
  assign memDone   = (state == FIN);
  assign memErr    = (state == FIN) && err_q;
  assign inst_out  = inst;
  assign dbg_state = state;

endmodule

// File: tb/tb_mc_datapath_bus.sv
// Directed bench for mc_datapath_bus: fetch, stores, load extension, errors, reset and RV32E.
// The bench acts as CPU control and as the bus slave; register values are observed through stores.
module tb_mc_datapath_bus;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enBranch = 0, pcUpdate = 0, irWrite = 0, regWrite = 0, addrSrc = 0;
  logic [1:0]  regSrc = 0, aluSrcA = 0, aluSrcB = 0;
  logic [2:0]  immedSrc = 0;
  logic [3:0]  aluOp = 0;
  logic        memReq = 0, memWr = 0, bus_ready = 0;
  logic [31:0] bus_rdata = 0;
  logic        memDone, memErr, bus_we, bus_valid;
  logic [31:0] inst_out, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [1:0]  dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_pc  = 32'h100;
  logic [31:0] exp_old = 32'h0;

  mc_datapath_bus #(.RESET_VEC(32'h100), .NREGS(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .enBranch(enBranch), .pcUpdate(pcUpdate), .irWrite(irWrite),
    .regWrite(regWrite), .addrSrc(addrSrc), .regSrc(regSrc), .immedSrc(immedSrc),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .memReq(memReq), .memWr(memWr),
    .memDone(memDone), .memErr(memErr), .inst_out(inst_out), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_we(bus_we), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues memReq now and plays the slave; returns in the memDone cycle.
  // waits < 0 means the slave never answers.
  task automatic do_mem(input logic wr, input logic asrc, input int waits, input logic [31:0] rdata,
                        input logic poke, output int lat, output int vcnt, output logic err,
                        output logic [31:0] addr, output logic [3:0] be, output logic [31:0] wdata,
                        output logic we, output logic stable);
    lat = 0; vcnt = 0; err = 0; addr = '0; be = '0; wdata = '0; we = 0; stable = 1;
    memWr = wr; addrSrc = asrc; memReq = 1;
    for (int c = 1; c <= 20; c++) begin
      step();
      memReq = 0;
      bus_ready = 0;
      if (memDone) begin
        lat = c;
        err = memErr;
        break;
      end
      if (bus_valid) begin
        vcnt++;
        if (vcnt == 1) begin
          addr = bus_addr; be = bus_be; wdata = bus_wdata; we = bus_we;
        end else if (addr !== bus_addr || be !== bus_be || wdata !== bus_wdata || we !== bus_we) begin
          stable = 0;
        end
        if (waits >= 0 && vcnt > waits) begin
          bus_ready = 1;
          bus_rdata = rdata;
        end
        if (poke && vcnt == 2) begin
          memReq = 1; memWr = 0; addrSrc = 0;
        end
      end
    end
    n_tests++;
    if (lat == 0) begin
      n_fail++;
      $display("FAIL mem_done_wait: no memDone within 20 cycles");
    end
  endtask

  task automatic fetch(input logic [31:0] word);
    int lat, vc; logic err, we, st; logic [31:0] a, wdv; logic [3:0] b;
    do_mem(1'b0, 1'b0, 0, word, 1'b0, lat, vc, err, a, b, wdv, we, st);
    n_tests++;
    if (lat != 2 || err !== 1'b0) begin
      n_fail++; $display("FAIL fetch_latency: got lat=%0d err=%b, expected lat=2 err=0", lat, err);
    end
    n_tests++;
    if (a !== exp_pc || b !== 4'hF) begin
      n_fail++; $display("FAIL fetch_addr: got %h be=%b, expected %h be=1111", a, b, exp_pc);
    end
    irWrite = 1; pcUpdate = 1; aluSrcA = 1; aluSrcB = 2; aluOp = 0;
    step();
    irWrite = 0; pcUpdate = 0;
    exp_old = exp_pc;
    exp_pc  = exp_pc + 32'd4;
    n_tests++;
    if (inst_out !== word) begin
      n_fail++; $display("FAIL fetch_inst: got %h expected %h", inst_out, word);
    end
  endtask

  task automatic reg_write_alu();
    immedSrc = 0; aluSrcA = 0; aluSrcB = 1; aluOp = 0; regSrc = 1; regWrite = 1;
    step();
    regWrite = 0;
  endtask

  // Current instruction must be "sw rs2, 0(x0)"; compares the stored word.
  task automatic store_word_check(input string name, input logic [31:0] exp);
    int lat, vc; logic err, we, st; logic [31:0] a, wdv; logic [3:0] b;
    immedSrc = 1; aluSrcA = 0; aluSrcB = 1; aluOp = 0;
    do_mem(1'b1, 1'b1, 0, 32'h0, 1'b0, lat, vc, err, a, b, wdv, we, st);
    n_tests++;
    if (wdv !== exp || b !== 4'hF || a !== 32'h0 || we !== 1'b1 || lat != 2) begin
      n_fail++;
      $display("FAIL %s: got wdata=%h be=%b addr=%h we=%b lat=%0d, expected wdata=%h be=1111 addr=0 we=1 lat=2",
               name, wdv, b, a, we, lat, exp);
    end
    step();
  endtask

  task automatic load_check(input string name, input logic [31:0] ld, input logic [31:0] rdata,
                            input logic [3:0] exp_be, input logic [31:0] exp_rd);
    int lat, vc; logic err, we, st; logic [31:0] a, wdv; logic [3:0] b;
    fetch(ld);
    immedSrc = 0; aluSrcA = 0; aluSrcB = 1; aluOp = 0;
    do_mem(1'b0, 1'b1, 0, rdata, 1'b0, lat, vc, err, a, b, wdv, we, st);
    n_tests++;
    if (lat != 2 || err !== 1'b0 || b !== exp_be || a !== 32'h100 || we !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_bus: got lat=%0d err=%b be=%b addr=%h we=%b, expected lat=2 err=0 be=%b addr=00000100 we=0",
               name, lat, err, b, a, we, exp_be);
    end
    regSrc = 2; regWrite = 1;
    step();
    regWrite = 0;
    fetch(32'h00302023);
    store_word_check(name, exp_rd);
  endtask

  task automatic test_reset();
    rst = 1;
    step(); step();
    n_tests++;
    if (bus_valid !== 0 || bus_we !== 0 || bus_be !== 0 || bus_addr !== 0 || bus_wdata !== 0) begin
      n_fail++; $display("FAIL reset_bus: got valid=%b we=%b be=%b addr=%h wdata=%h, expected all 0",
                         bus_valid, bus_we, bus_be, bus_addr, bus_wdata);
    end
    n_tests++;
    if (memDone !== 0 || memErr !== 0 || inst_out !== 0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_ctl: got done=%b err=%b inst=%h state=%0d, expected 0 0 0 0",
                         memDone, memErr, inst_out, dbg_state);
    end
    rst = 0;
  endtask

  task automatic test_fetch();
    fetch(32'h00500093);
    reg_write_alu();
  endtask

  task automatic test_store_byte();
    int lat, vc; logic err, we, st; logic [31:0] a, wdv; logic [3:0] b;
    fetch(32'h0A500113);
    reg_write_alu();
    fetch(32'h202001A3);
    immedSrc = 1; aluSrcA = 0; aluSrcB = 1; aluOp = 0;
    do_mem(1'b1, 1'b1, 2, 32'h0, 1'b0, lat, vc, err, a, b, wdv, we, st);
    n_tests++;
    if (a !== 32'h200 || b !== 4'b1000 || wdv !== 32'hA5A5A5A5 || we !== 1'b1) begin
      n_fail++; $display("FAIL sb_lanes: got addr=%h be=%b wdata=%h we=%b, expected 00000200 1000 a5a5a5a5 1",
                         a, b, wdv, we);
    end
    n_tests++;
    if (vc != 3 || lat != 4 || err !== 1'b0 || st !== 1'b1) begin
      n_fail++; $display("FAIL sb_timing: got valid_cycles=%0d lat=%0d err=%b stable=%b, expected 3 4 0 1",
                         vc, lat, err, st);
    end
    step();
  endtask

  task automatic test_load_ext();
    load_check("lb_sign", 32'h10300183, 32'h80FF7F00, 4'b1000, 32'hFFFFFF80);
    load_check("lbu_zero", 32'h10304183, 32'h80FF7F00, 4'b1000, 32'h00000080);
    load_check("lh_sign", 32'h10201183, 32'h80FF7F00, 4'b1100, 32'hFFFF80FF);
  endtask

  // Last fetch loaded PC and IR together; old_pc must hold the pre-update PC.
  task automatic test_old_pc();
    int lat, vc; logic err, we, st; logic [31:0] a, wdv; logic [3:0] b;
    immedSrc = 1; aluSrcA = 2; aluSrcB = 3; aluOp = 0;
    do_mem(1'b1, 1'b1, 0, 32'h0, 1'b0, lat, vc, err, a, b, wdv, we, st);
    n_tests++;
    if (a !== exp_old) begin
      n_fail++; $display("FAIL old_pc: got addr=%h expected %h", a, exp_old);
    end
    step();
  endtask

  task automatic test_misaligned();
    int lat, vc; logic err, we, st; logic [31:0] a, wdv; logic [3:0] b;
    fetch(32'h10202183);
    immedSrc = 0; aluSrcA = 0; aluSrcB = 1; aluOp = 0;
    do_mem(1'b0, 1'b1, 0, 32'hDEADBEEF, 1'b0, lat, vc, err, a, b, wdv, we, st);
    n_tests++;
    if (lat != 1 || err !== 1'b1 || vc != 0) begin
      n_fail++; $display("FAIL misaligned: got lat=%0d err=%b valid_cycles=%0d, expected 1 1 0", lat, err, vc);
    end
    irWrite = 1;
    step();
    irWrite = 0;
    n_tests++;
    if (inst_out !== 32'h10202183) begin
      n_fail++; $display("FAIL misaligned_mdr: got %h expected 10202183", inst_out);
    end
  endtask

  task automatic test_timeout();
    int lat, vc; logic err, we, st; logic [31:0] a, wdv; logic [3:0] b;
    do_mem(1'b0, 1'b0, -1, 32'h12345678, 1'b1, lat, vc, err, a, b, wdv, we, st);
    n_tests++;
    if (vc != 4 || lat != 5 || err !== 1'b1 || a !== exp_pc) begin
      n_fail++; $display("FAIL timeout: got valid_cycles=%0d lat=%0d err=%b addr=%h, expected 4 5 1 %h",
                         vc, lat, err, a, exp_pc);
    end
    irWrite = 1;
    step();
    irWrite = 0;
    n_tests++;
    if (inst_out !== 32'h10202183) begin
      n_fail++; $display("FAIL timeout_mdr: got %h expected 10202183", inst_out);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (bus_valid !== 1'b0 || memDone !== 1'b0) begin
        n_fail++; $display("FAIL req_ignored: cycle %0d got valid=%b done=%b, expected 0 0", i, bus_valid, memDone);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    memWr = 0; addrSrc = 0; memReq = 1;
    step();
    memReq = 0;
    n_tests++;
    if (bus_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_start: got valid=%b expected 1", bus_valid);
    end
    step();
    rst = 1;
    step();
    rst = 0;
    bus_ready = 1;
    bus_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (bus_valid !== 1'b0 || memDone !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid: cycle %0d got valid=%b done=%b, expected 0 0", i, bus_valid, memDone);
      end
      step();
    end
    bus_ready = 0;
    exp_pc = 32'h100;
    n_tests++;
    if (inst_out !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_inst: got %h expected 00000000", inst_out);
    end
    fetch(32'h05500893);
  endtask

  task automatic test_rv32e();
    reg_write_alu();
    fetch(32'h01102023);
    store_word_check("x17_reads_zero", 32'h0);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_byte();
    test_load_ext();
    test_old_pc();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_rv32e();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
